// File: rtl/ctrl_pkg.sv
// Shared control definitions: state encoding, opcodes, mux selects, control word.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    // Per-state control word; pc_update and branch never leave the control unit.
    typedef struct packed {
        logic             adr_src;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic             pc_update;
        logic             branch;
        logic             halted;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decode: state to datapath control word.
module main_fsm_outdec
    import ctrl_pkg::*;
(
    input  state_t     state,
    output ctrl_word_t ctrl
);

    // Control word per state; anything not set stays inactive.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write   = 1'b1;
                ctrl.pc_update  = 1'b1;
                ctrl.alu_src_b  = SRCB_FOUR;
                ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEMWB: begin
                ctrl.result_src = RES_DATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.branch    = 1'b1;
            end
            S_JAL: begin
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_update = 1'b1;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM. Optional illegal-opcode trap: MAIN_FSM_ILLEGAL_TRAP_EN.
module main_fsm
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    output logic             pcWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic [SEL_W-1:0] resultSrc,
    output logic [SEL_W-1:0] aluSrcA,
    output logic [SEL_W-1:0] aluSrcB,
    output logic [SEL_W-1:0] aluOp,
    output logic [SEL_W-1:0] immSrc,
    output logic [STATE_W-1:0] state
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    ,output logic            illegal
`endif
);

    state_t     state_q;
    state_t     state_d;
    state_t     dec_state;
    ctrl_word_t ctrl;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic; op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMREAD;
                else if (op == OP_SW) state_d = S_MEMWRITE;
                else                  state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // While reset is held the outputs look like FETCH with writes suppressed.
    assign dec_state = reset ? S_FETCH : state_q;

    main_fsm_outdec u_outdec (
        .state (dec_state),
        .ctrl  (ctrl)
    );

    // Output drive: write enables gated by reset, pcWrite is the Mealy branch term.
    always_comb begin
        pcWrite   = ~reset & (ctrl.pc_update | (ctrl.branch & zero));
        irWrite   = ~reset & ctrl.ir_write;
        regWrite  = ~reset & ctrl.reg_write;
        memWrite  = ~reset & ctrl.mem_write;
        adrSrc    = ctrl.adr_src;
        resultSrc = ctrl.result_src;
        aluSrcA   = ctrl.alu_src_a;
        aluSrcB   = ctrl.alu_src_b;
        aluOp     = ctrl.alu_op;
        state     = STATE_W'(state_q);
    end

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    // Trap indicator, only meaningful once out of reset.
    assign illegal = ~reset & ctrl.halted;
`else
    logic unused_halted;
    assign unused_halted = ctrl.halted;
`endif

    // Immediate format select, decoded straight from the opcode.
    always_comb begin
        immSrc = IMM_I;
        case (op)
            OP_LW, OP_I: immSrc = IMM_I;
            OP_SW:       immSrc = IMM_S;
            OP_BEQ:      immSrc = IMM_B;
            OP_JAL:      immSrc = IMM_J;
            default:     immSrc = IMM_I;
        endcase
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle main control FSM for the RISC-V core. It sequences the shared datapath (single ALU, single memory port, instruction register) through Fetch/Decode/Execute/Writeback steps per instruction. It is a Moore machine plus one Mealy term (`pcWrite`). It drives `aluOp` into the existing ALU decoder and `immSrc` into the immediate extender, and sits beside the datapath at the top of the control unit.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `op`  in  7  opcode from the instruction register, stable from Decode onward.
- `zero`  in  1  ALU zero flag.
- `pcWrite`  out  1  PC load enable, equal to `pcUpdate | (branch & zero)`.
- `adrSrc`  out  1  memory address select: 0 = PC, 1 = result.
- `memWrite`  out  1  data memory write enable.
- `irWrite`  out  1  instruction register load enable.
- `regWrite`  out  1  register file write enable.
- `resultSrc`  out  2  result mux select: 00 = ALUOut, 01 = data, 10 = ALUResult.
- `aluSrcA`  out  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- `aluSrcB`  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4.
- `aluOp`  out  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- `immSrc`  out  2  combinational from `op`: lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00.
- `state`  out  4  current state encoding, for verification.
- `illegal`  out  1  only with the macro; see Configuration.

## Operation
- **State encoding** (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 11.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE, by `op`:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECUTER.
    - 0010011 → EXECUTEI.
    - 1100011 → BEQ.
    - 1101111 → JAL.
    - any other value → FETCH (macro off).
  - MEMADR: lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER, EXECUTEI, JAL → ALUWB→FETCH.
  - BEQ→FETCH.
  - Encodings 12–15 (and 11 when the macro is off) → FETCH.
- **Outputs per state.** Any signal not listed is 0.
  - FETCH: `irWrite` = 1, `pcUpdate` = 1, `aluSrcB` = 10, `resultSrc` = 10.
  - DECODE: `aluSrcA` = 01, `aluSrcB` = 01.
  - MEMADR: `aluSrcA` = 10, `aluSrcB` = 01.
  - MEMREAD: `adrSrc` = 1.
  - MEMWB: `resultSrc` = 01, `regWrite` = 1.
  - MEMWRITE: `adrSrc` = 1, `memWrite` = 1.
  - EXECUTER: `aluSrcA` = 10, `aluOp` = 10.
  - EXECUTEI: `aluSrcA` = 10, `aluSrcB` = 01, `aluOp` = 10.
  - ALUWB: `regWrite` = 1.
  - BEQ: `aluSrcA` = 10, `aluOp` = 01, `branch` = 1.
  - JAL: `aluSrcA` = 01, `aluSrcB` = 10, `pcUpdate` = 1.
- `pcUpdate` and `branch` are internal signals only.

## Timing
- **Reset:**
  - `reset` sampled high → state = FETCH next edge.
  - While `reset` is high: `pcWrite`, `irWrite`, `regWrite`, `memWrite` forced 0.
  - While `reset` is high, all other outputs show FETCH values; `illegal` = 0.
- **Reset mid-instruction:** aborts with no further write enable asserted. The first FETCH after release is a full fetch.
- **Cycles per instruction, FETCH inclusive:** lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- **`pcWrite` in BEQ:** follows `zero` combinationally in the same cycle, with no register.
- **Sampling:** `op` is sampled only in DECODE and MEMADR; changes in other states are ignored.

## Configuration
- **`MAIN_FSM_ILLEGAL_TRAP_EN` defined:**
  - An unlisted `op` in DECODE goes to HALT.
  - HALT holds with all write enables 0 and `illegal` = 1 until reset.
- **Undefined:**
  - An unlisted `op` returns to FETCH and is treated as a NOP.
  - Port `illegal` is absent.
  - HALT is unreachable.

## Structure
- **Shared package `ctrl_pkg`:**
  - State constants.
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL.
  - Mux-select constants for `resultSrc`, `aluSrcA`, `aluSrcB`, `aluOp`.
- **Sub-module `main_fsm_outdec`:** combinational mapping from state to control word.
- **In `main_fsm`:** state register, next-state logic, `pcWrite`, `immSrc`.

## Test plan
- **Reset mid-op:** reset in MEMADR with `op` = 0000011 → next `state` = 0, no `regWrite` pulse. After release, FETCH asserts `irWrite` = 1, `pcWrite` = 1.
- **lw:** `op` = 0000011 → states 0,1,2,3,4,0. MEMWB shows `resultSrc` = 01, `regWrite` = 1. `immSrc` = 00.
- **sw:** `op` = 0100011 → states 0,1,2,5,0. `memWrite` = 1 only in MEMWRITE, with `adrSrc` = 1. `immSrc` = 01.
- **beq:** `op` = 1100011 with `zero` = 1 → `pcWrite` = 1 in BEQ, `aluOp` = 01. With `zero` = 0 → `pcWrite` = 0. Sequence 0,1,9,0.
- **R then jal:** `op` = 0110011 → 0,1,6,8,0 with `aluOp` = 10 in EXECUTER. `op` = 1101111 → 0,1,10,8,0 with `pcWrite` = 1 in JAL and `immSrc` = 11.
- **Illegal opcode:** `op` = 1111111 → macro off: DECODE→FETCH, no writes. Macro on: `state` = 11, `illegal` = 1, held for 10 cycles, cleared by reset.
